// File: rtl/cpu6_scoreboard_pkg.sv
// cpu6_scoreboard_pkg: register-file geometry macros, types and a one-hot helper shared by the scoreboard
`ifndef CPU6_RFIDX_WIDTH
`define CPU6_RFIDX_WIDTH 5
`endif
`ifndef CPU6_RF_NUM
`define CPU6_RF_NUM 32
`endif
package cpu6_scoreboard_pkg;
  localparam int RFIDX_W = `CPU6_RFIDX_WIDTH;
  localparam int RF_NUM = `CPU6_RF_NUM;
  typedef logic [RFIDX_W-1:0] rfidx_t;
  typedef logic [RF_NUM-1:0] rfvec_t;
  // x0 never produces a bit, so busy[0] can never be set or cleared
  function automatic rfvec_t rf_onehot(input logic en, input rfidx_t idx);
    rf_onehot = (en && idx != '0) ? rfvec_t'(1) << idx : '0;
  endfunction
endpackage

// File: rtl/cpu6_sb_outcnt.sv
// cpu6_sb_outcnt: saturating outstanding-op counter with overflow/underflow error flags
module cpu6_sb_outcnt #(
  parameter int MAXOUT = 4,
  parameter int CNTW = 4
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            inc,
  input  logic            dec,
  input  logic            dec_ok,
  output logic [CNTW-1:0] cnt,
  output logic            full,
  output logic            ovf,
  output logic            unf
);
  localparam logic [CNTW-1:0] MAXC = CNTW'(MAXOUT);
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic up, dn;
  // a rejected writeback frees no slot; the count pins at 0 and MAXOUT on protocol errors
  always_comb begin
    full = cnt_q == MAXC;
    ovf = inc && full && !dec;
    unf = dec && cnt_q == '0 && !inc;
    up = inc && !(dec && dec_ok);
    dn = dec && dec_ok && !inc;
    cnt_d = (up && !full) ? cnt_q + CNTW'(1) : (dn && cnt_q != '0) ? cnt_q - CNTW'(1) : cnt_q;
  end
  // counter state
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
  assign cnt = cnt_q;
endmodule

// File: rtl/cpu6_scoreboard.sv
// cpu6_scoreboard: long-latency write scoreboard and decode stall (CPU6_SB_WBBYPASS_EN enables writeback-to-decode bypass)
module cpu6_scoreboard
  import cpu6_scoreboard_pkg::*;
#(
  parameter int MAXOUT = 4,
  parameter int CNTW = 4
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic [`CPU6_RFIDX_WIDTH-1:0] rs1idxD,
  input  logic [`CPU6_RFIDX_WIDTH-1:0] rs2idxD,
  input  logic                         rs1useD,
  input  logic                         rs2useD,
  input  logic [`CPU6_RFIDX_WIDTH-1:0] rdD,
  input  logic                         rdwenD,
  input  logic                         lliD,
  input  logic                         issueE,
  input  logic [`CPU6_RFIDX_WIDTH-1:0] issuerdE,
  input  logic                         wbvalid,
  input  logic [`CPU6_RFIDX_WIDTH-1:0] wbrd,
  output logic                         stallD,
  output logic [`CPU6_RF_NUM-1:0]      busy,
  output logic [CNTW-1:0]              outcnt,
  output logic                         sberr
);
  rfvec_t busy_q, busy_d, pend;
  logic sberr_q, sberr_d, spur, full, ovf, unf, full_haz;
  cpu6_sb_outcnt #(.MAXOUT(MAXOUT), .CNTW(CNTW)) u_outcnt (
    .clk(clk),
    .resetn(resetn),
    .inc(issueE),
    .dec(wbvalid),
    .dec_ok(!spur),
    .cnt(outcnt),
    .full(full),
    .ovf(ovf),
    .unf(unf)
  );
  // set beats clear on the same register; an offending issue or writeback leaves busy untouched
  always_comb begin
    spur = wbvalid && wbrd != '0 && !busy_q[wbrd] && !(issueE && issuerdE == wbrd);
    busy_d = (busy_q & ~rf_onehot(wbvalid && !spur && !unf, wbrd)) | rf_onehot(issueE && !ovf, issuerdE);
    sberr_d = sberr_q || spur || ovf || unf;
  end
  // pending view seen by decode; with the bypass a register retiring this cycle is already readable
  always_comb begin
`ifdef CPU6_SB_WBBYPASS_EN
    pend = busy_q & ~rf_onehot(wbvalid, wbrd);
    full_haz = lliD && full && !wbvalid;
`else
    pend = busy_q;
    full_haz = lliD && full;
`endif
    stallD = (rs1useD && pend[rs1idxD]) || (rs2useD && pend[rs2idxD]) || (rdwenD && pend[rdD]) || full_haz;
  end
  // busy vector and sticky error
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      busy_q <= '0;
      sberr_q <= 1'b0;
    end else begin
      busy_q <= busy_d;
      sberr_q <= sberr_d;
    end
  end
  assign busy = busy_q;
  assign sberr = sberr_q;
endmodule

// File: tb/tb_cpu6_scoreboard.sv
// tb_cpu6_scoreboard: randomized and directed checks of cpu6_scoreboard against a behavioural model
module tb_cpu6_scoreboard;
  localparam int MAXOUT = 4;
`ifdef CPU6_SB_WBBYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  logic clk = 1'b0, resetn = 1'b0;
  logic [4:0] rs1idxD, rs2idxD, rdD, issuerdE, wbrd;
  logic rs1useD, rs2useD, rdwenD, lliD, issueE, wbvalid;
  logic stallD, sberr;
  logic [31:0] busy;
  logic [3:0] outcnt;
  int total = 0, bad = 0;
  bit mb[32];
  int mcnt;
  bit merr;
  always #5 clk = ~clk;
  cpu6_scoreboard #(.MAXOUT(MAXOUT), .CNTW(4)) dut (
    .clk(clk), .resetn(resetn),
    .rs1idxD(rs1idxD), .rs2idxD(rs2idxD), .rs1useD(rs1useD), .rs2useD(rs2useD),
    .rdD(rdD), .rdwenD(rdwenD), .lliD(lliD),
    .issueE(issueE), .issuerdE(issuerdE), .wbvalid(wbvalid), .wbrd(wbrd),
    .stallD(stallD), .busy(busy), .outcnt(outcnt), .sberr(sberr)
  );
  function automatic logic [31:0] mvec();
    logic [31:0] v = '0;
    for (int i = 1; i < 32; i++) v[i] = mb[i];
    return v;
  endfunction
  function automatic bit mpend(int r);
    return r != 0 && mb[r] && !(BYP && wbvalid && int'(wbrd) == r);
  endfunction
  function automatic bit mstall();
    return (rs1useD && mpend(int'(rs1idxD))) || (rs2useD && mpend(int'(rs2idxD))) ||
           (rdwenD && mpend(int'(rdD))) || (lliD && mcnt == MAXOUT && !(BYP && wbvalid));
  endfunction
  task automatic mreset();
    for (int i = 0; i < 32; i++) mb[i] = 1'b0;
    mcnt = 0;
    merr = 1'b0;
  endtask
  task automatic idle();
    rs1idxD = '0; rs2idxD = '0; rdD = '0; issuerdE = '0; wbrd = '0;
    rs1useD = 0; rs2useD = 0; rdwenD = 0; lliD = 0; issueE = 0; wbvalid = 0;
  endtask
  task automatic tick();
    bit spur, ovf, unf, decv;
    int delta;
    @(posedge clk);
    spur = wbvalid && wbrd != 0 && !mb[wbrd] && !(issueE && issuerdE == wbrd);
    ovf = issueE && mcnt == MAXOUT && !wbvalid;
    unf = wbvalid && mcnt == 0 && !issueE;
    decv = wbvalid && !spur;
    merr = merr | spur | ovf | unf;
    if (decv && wbrd != 0 && !unf) mb[wbrd] = 1'b0;
    if (issueE && issuerdE != 0 && !ovf) mb[issuerdE] = 1'b1;
    delta = int'(issueE) - int'(decv);
    if (delta > 0 && mcnt < MAXOUT) mcnt++;
    if (delta < 0 && mcnt > 0) mcnt--;
    @(negedge clk);
  endtask
  task automatic test_reset();
    idle();
    resetn = 1'b0;
    #1;
    mreset();
    total++; if (busy !== 32'h0) begin bad++; $display("FAIL reset_busy got=%h exp=0", busy); end
    total++; if (outcnt !== 4'd0) begin bad++; $display("FAIL reset_outcnt got=%0d exp=0", outcnt); end
    total++; if (sberr !== 1'b0) begin bad++; $display("FAIL reset_sberr got=%b exp=0", sberr); end
    total++; if (stallD !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b exp=0", stallD); end
    @(negedge clk);
    resetn = 1'b1;
  endtask
  task automatic test_raw();
    idle(); issueE = 1; issuerdE = 5;
    tick();
    idle(); rs1idxD = 5; rs1useD = 1;
    #1;
    total++; if (stallD !== 1'b1) begin bad++; $display("FAIL raw_stall_n1 got=%b exp=1", stallD); end
    tick();
    total++; if (stallD !== 1'b1) begin bad++; $display("FAIL raw_stall_hold got=%b exp=1", stallD); end
    wbvalid = 1; wbrd = 5;
    #1;
    total++; if (stallD !== !BYP) begin bad++; $display("FAIL raw_stall_wb got=%b exp=%b", stallD, !BYP); end
    tick();
    wbvalid = 0;
    #1;
    total++; if (stallD !== 1'b0) begin bad++; $display("FAIL raw_stall_after got=%b exp=0", stallD); end
    total++; if (busy[5] !== 1'b0 || outcnt !== 4'd0) begin bad++; $display("FAIL raw_retire busy=%h cnt=%0d exp busy5=0 cnt=0", busy, outcnt); end
    idle();
  endtask
  task automatic test_x0();
    idle(); issueE = 1; issuerdE = 0;
    tick();
    idle();
    total++; if (busy !== 32'h0 || outcnt !== 4'd1) begin bad++; $display("FAIL x0_issue busy=%h cnt=%0d exp busy=0 cnt=1", busy, outcnt); end
    rs1useD = 1; rs2useD = 1; rdwenD = 1;
    #1;
    total++; if (stallD !== 1'b0) begin bad++; $display("FAIL x0_stall got=%b exp=0", stallD); end
    idle(); wbvalid = 1; wbrd = 0;
    tick();
    idle();
    total++; if (outcnt !== 4'd0 || sberr !== 1'b0) begin bad++; $display("FAIL x0_wb cnt=%0d sberr=%b exp cnt=0 sberr=0", outcnt, sberr); end
  endtask
  task automatic test_full();
    for (int r = 1; r <= 4; r++) begin
      idle(); issueE = 1; issuerdE = 5'(r);
      tick();
    end
    idle(); lliD = 1;
    #1;
    total++; if (stallD !== 1'b1 || outcnt !== 4'd4) begin bad++; $display("FAIL full_stall stall=%b cnt=%0d exp stall=1 cnt=4", stallD, outcnt); end
    wbvalid = 1; wbrd = 2;
    #1;
    total++; if (stallD !== !BYP) begin bad++; $display("FAIL full_wb_stall got=%b exp=%b", stallD, !BYP); end
    tick();
    idle();
    total++; if (outcnt !== 4'd3 || busy !== 32'h1A) begin bad++; $display("FAIL full_retire cnt=%0d busy=%h exp cnt=3 busy=1a", outcnt, busy); end
    for (int r = 1; r <= 4; r++) begin
      if (r == 2) continue;
      idle(); wbvalid = 1; wbrd = 5'(r);
      tick();
    end
    idle();
  endtask
  task automatic test_same();
    idle(); issueE = 1; issuerdE = 7;
    tick();
    wbvalid = 1; wbrd = 7;
    tick();
    idle();
    total++; if (busy[7] !== 1'b1 || outcnt !== 4'd1) begin bad++; $display("FAIL same_cycle busy7=%b cnt=%0d exp busy7=1 cnt=1", busy[7], outcnt); end
    wbvalid = 1; wbrd = 7;
    tick();
    idle();
    total++; if (busy !== 32'h0 || outcnt !== 4'd0 || sberr !== 1'b0) begin bad++; $display("FAIL same_drain busy=%h cnt=%0d sberr=%b exp 0/0/0", busy, outcnt, sberr); end
  endtask
  task automatic test_random();
    int cand[$];
    for (int n = 0; n < 400; n++) begin
      idle();
      rs1idxD = 5'($urandom_range(0, 7)); rs2idxD = 5'($urandom_range(0, 7)); rdD = 5'($urandom_range(0, 7));
      rs1useD = 1'($urandom); rs2useD = 1'($urandom); rdwenD = 1'($urandom); lliD = 1'($urandom);
      issueE = ($urandom_range(0, 7) < 3) && (mcnt < MAXOUT || $urandom_range(0, 15) == 0);
      issuerdE = 5'($urandom_range(0, 7));
      cand.delete();
      for (int i = 1; i < 8; i++) if (mb[i]) cand.push_back(i);
      if (mcnt > 0 && $urandom_range(0, 7) < 3) begin
        wbvalid = 1;
        wbrd = cand.size() == 0 ? 5'd0 : 5'(cand[$urandom_range(0, cand.size() - 1)]);
      end
      if ($urandom_range(0, 39) == 0) begin
        wbvalid = 1; wbrd = 5'($urandom_range(0, 15));
      end
      #1;
      total++; if (stallD !== mstall()) begin bad++; $display("FAIL rnd_stall n=%0d got=%b exp=%b", n, stallD, mstall()); end
      tick();
      total++; if (busy !== mvec() || outcnt !== 4'(mcnt) || sberr !== merr) begin
        bad++; $display("FAIL rnd_state n=%0d busy=%h cnt=%0d sberr=%b exp busy=%h cnt=%0d sberr=%b", n, busy, outcnt, sberr, mvec(), mcnt, merr);
      end
    end
    idle();
  endtask
  task automatic test_sberr();
    test_reset();
    issueE = 1; issuerdE = 3;
    tick();
    idle(); wbvalid = 1; wbrd = 9;
    tick();
    idle();
    total++; if (sberr !== 1'b1 || busy !== 32'h8 || outcnt !== 4'd1) begin bad++; $display("FAIL sberr_set sberr=%b busy=%h cnt=%0d exp 1/8/1", sberr, busy, outcnt); end
    wbvalid = 1; wbrd = 3;
    tick();
    idle(); tick(); tick();
    total++; if (sberr !== 1'b1 || outcnt !== 4'd0) begin bad++; $display("FAIL sberr_sticky sberr=%b cnt=%0d exp 1/0", sberr, outcnt); end
  endtask
  task automatic test_reset_mid();
    test_reset();
    for (int r = 4; r <= 7; r++) begin
      idle(); issueE = 1; issuerdE = 5'(r);
      tick();
    end
    idle(); wbvalid = 1; wbrd = 0;
    tick();
    idle();
    total++; if (busy !== 32'hF0 || outcnt !== 4'd3) begin bad++; $display("FAIL mid_setup busy=%h cnt=%0d exp f0/3", busy, outcnt); end
    #2 resetn = 1'b0;
    #1;
    mreset();
    total++; if (busy !== 32'h0 || outcnt !== 4'd0 || sberr !== 1'b0) begin bad++; $display("FAIL mid_reset busy=%h cnt=%0d sberr=%b exp 0/0/0", busy, outcnt, sberr); end
    @(negedge clk);
    resetn = 1'b1;
  endtask
  initial begin
    test_reset();
    test_raw();
    test_x0();
    test_full();
    test_same();
    test_random();
    test_sberr();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
